// File: rtl/imm_gen_pipe_if.sv
// Decode-side instruction bus: instruction/tag in, extended immediate/format/tag out,
// each direction with its own valid/ready pair.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, instr, in_tag, out_ready,
    input  in_ready, out_valid, imm, fmt, out_tag
  );

  modport slave (
    input  in_valid, instr, in_tag, out_ready,
    output in_ready, out_valid, imm, fmt, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode into a registered output
// stage backed by one skid entry, so upstream sees a registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } ent_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  ent_t   out_q, out_d;
  ent_t   skid_q, skid_d;
  ent_t   dec;
  logic   accept;

  logic [31:0] ins;
  logic [2:0]  f3;
  assign ins = bus.instr;
  assign f3  = ins[14:12];

  // Signed casts sign-extend to XLEN; unsigned casts zero-extend.
  always_comb begin
    dec     = '0;
    dec.tag = bus.in_tag;
    case (ins[6:0])
      7'b0000011, 7'b1100111: begin
        dec.fmt = F_I;
        dec.imm = XLEN'($signed(ins[31:20]));
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.fmt = F_SHAMT;
          if (XLEN == 64) dec.imm = XLEN'(ins[25:20]);
          else            dec.imm = XLEN'(ins[24:20]);
        end else begin
          dec.fmt = F_I;
          dec.imm = XLEN'($signed(ins[31:20]));
        end
      end
      7'b0100011: begin
        dec.fmt = F_S;
        dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = F_B;
        dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = F_U;
        dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = F_J;
        dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      default: dec.fmt = F_NONE;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          out_d   = dec;
        end
        ONE: begin
          if (accept && bus.out_ready) begin
            out_d = dec;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (bus.out_ready) begin
            state_d = EMPTY;
          end
        end
        TWO: if (bus.out_ready) begin
          state_d = ONE;
          out_d   = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.imm       = out_q.imm;
  assign bus.fmt       = out_q.fmt;
  assign bus.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboarded bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int checks = 0;
  int failures = 0;
  int pops32 = 0;

  logic [31:0] sv_ins[6] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                             32'hFFDFF06F, 32'h4030D093, 32'h002081B3};
  logic [63:0] sv_imm[6] = '{64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000,
                             64'hFFFFFFFC, 64'h3, 64'h0};
  logic [2:0]  sv_fmt[6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] tag);
    b32.in_valid = v;
    b32.instr    = ins;
    b32.in_tag   = tag;
  endtask

  task automatic push32(input logic [63:0] imm, input logic [2:0] f, input logic [31:0] tag);
    exp_t e;
    e.imm = imm; e.fmt = f; e.tag = tag;
    q32.push_back(e);
  endtask

  task automatic push64(input logic [63:0] imm, input logic [2:0] f, input logic [31:0] tag);
    exp_t e;
    e.imm = imm; e.fmt = f; e.tag = tag;
    q64.push_back(e);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A result transfers on the rising edge following this sample point.
  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      exp_t e;
      pops32++;
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected32 actual_tag=0x%0h required=none", b32.out_tag);
      end else begin
        e = q32.pop_front();
        chk("imm32", 64'(b32.imm), e.imm);
        chk("fmt32", 64'(b32.fmt), 64'(e.fmt));
        chk("tag32", 64'(b32.out_tag), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b64.out_valid && b64.out_ready) begin
      exp_t e;
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected64 actual_tag=0x%0h required=none", b64.out_tag);
      end else begin
        e = q64.pop_front();
        chk("imm64", b64.imm, e.imm);
        chk("fmt64", 64'(b64.fmt), 64'(e.fmt));
        chk("tag64", 64'(b64.out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv(1'b0, 32'h0, 32'h0);
    b32.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.instr = 32'h0; b64.in_tag = 32'h0; b64.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("rst_imm", 64'(b32.imm), 64'd0);
    chk("rst_fmt", 64'(b32.fmt), 64'd0);

    // Single addi, 1-cycle latency
    b32.out_ready = 1'b1;
    drv(1'b1, 32'hFFF00093, 32'h100);
    push32(64'hFFFFFFFF, 3'd1, 32'h100);
    cyc();
    chk("lat_valid", 64'(b32.out_valid), 64'd1);

    // Back-to-back stream
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, sv_ins[i], 32'h200 + i);
      push32(sv_imm[i], sv_fmt[i], 32'h200 + i);
      cyc();
      chk("stream_valid", 64'(b32.out_valid), 64'd1);
      chk("stream_ready", 64'(b32.in_ready), 64'd1);
    end
    drv(1'b0, 32'h0, 32'h0);
    cyc();
    chk("stream_drained", 64'(q32.size()), 64'd0);
    chk("stream_pops", 64'(pops32), 64'd7);
    chk("stream_empty", 64'(b32.out_valid), 64'd0);

    // Backpressure into skid, third request ignored
    b32.out_ready = 1'b0;
    drv(1'b1, 32'h123452B7, 32'h301);
    push32(64'h12345000, 3'd4, 32'h301);
    cyc();
    chk("bp_ready1", 64'(b32.in_ready), 64'd1);
    drv(1'b1, 32'hFFDFF06F, 32'h302);
    push32(64'hFFFFFFFC, 3'd5, 32'h302);
    cyc();
    chk("bp_full", 64'(b32.in_ready), 64'd0);
    drv(1'b1, 32'hFFF00093, 32'h303);
    cyc();
    chk("bp_ignored", 64'(b32.in_ready), 64'd0);
    chk("bp_hold_imm", 64'(b32.imm), 64'h12345000);
    chk("bp_hold_tag", 64'(b32.out_tag), 64'h301);
    drv(1'b0, 32'h0, 32'h0);
    b32.out_ready = 1'b1;
    cyc();
    chk("bp_ready_back", 64'(b32.in_ready), 64'd1);
    chk("bp_second_tag", 64'(b32.out_tag), 64'h302);
    cyc();
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Flush while full with a simultaneous request
    b32.out_ready = 1'b0;
    drv(1'b1, 32'h123452B7, 32'h401);
    cyc();
    drv(1'b1, 32'hFFDFF06F, 32'h402);
    cyc();
    chk("fl_full", 64'(b32.in_ready), 64'd0);
    flush = 1'b1;
    drv(1'b1, 32'hFFF00093, 32'h403);
    cyc();
    flush = 1'b0;
    drv(1'b0, 32'h0, 32'h0);
    chk("fl_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    cyc(3);
    chk("fl_nothing", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset while full
    b32.out_ready = 1'b0;
    drv(1'b1, 32'h123452B7, 32'h501);
    cyc();
    drv(1'b1, 32'hFFDFF06F, 32'h502);
    cyc();
    drv(1'b0, 32'h0, 32'h0);
    chk("rs_full", 64'(b32.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid_async", 64'(b32.out_valid), 64'd0);
    chk("rs_ready_async", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    chk("rs_imm", 64'(b32.imm), 64'd0);
    chk("rs_fmt", 64'(b32.fmt), 64'd0);
    chk("rs_tag", 64'(b32.out_tag), 64'd0);
    chk("rs_valid", 64'(b32.out_valid), 64'd0);
    chk("rs_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    cyc(2);

    // XLEN=64 instance
    b64.in_valid = 1'b1; b64.instr = 32'h800002B7; b64.in_tag = 32'h601;
    push64(64'hFFFFFFFF80000000, 3'd4, 32'h601);
    cyc();
    b64.instr = 32'h03F09093; b64.in_tag = 32'h602;
    push64(64'h3F, 3'd6, 32'h602);
    cyc();
    b64.in_valid = 1'b0;
    cyc(2);
    chk("x64_drained", 64'(q64.size()), 64'd0);
    chk("x32_drained", 64'(q32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount), sign- or zero-extends to XLEN, and reports the decoded format.
- Registered output with valid/ready handshake and a 2-entry skid buffer, so decode can stall without losing instructions.
- Carries a sideband tag (e.g. PC) alongside each result.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction present on instr/in_tag.
- in_ready  out  1  block can accept an instruction this cycle.
- instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result this cycle.
- imm  out  XLEN  extended immediate.
- fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_tag  out  TAG_W  tag of the presented result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Decode by opcode instr[6:0]:
  - 0000011, 1100111, 0010011 (funct3 not 001/101) -> I: sign-extend instr[31:20].
  - 0010011 with funct3 001/101 -> SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64); funct7 ignored.
  - 0100011 -> S: sign-extend {instr[31:25], instr[11:7]}.
  - 1100011 -> B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 0110111, 0010111 -> U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 -> J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Any other opcode -> fmt 0, imm all zeros. Not an error, no flag.
- Decode is combinational on the input side. The result is registered, so latency is exactly 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
- Storage: an output register (OUT) plus one skid entry (SKID). States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & out_ready -> ONE; OUT takes the new entry.
    - Accept & !out_ready -> TWO; new entry to SKID.
    - No accept & out_ready -> EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0.
    - out_ready -> ONE; SKID moves to OUT.
    - Otherwise hold.
- in_ready is a register output (1 in EMPTY/ONE, 0 in TWO). It must not depend combinationally on out_ready.
- Order is strictly FIFO. Throughput is 1 per cycle while out_ready is held high.
- While out_valid=1 and out_ready=0, imm, fmt and out_tag hold stable.
- in_valid while in_ready=0 is ignored; no state change.
- flush: next state is EMPTY and any same-cycle input is dropped. flush has priority over all handshakes.
- Reset: state EMPTY, out_valid=0, in_ready=1 (asserted while rst_n low and after release), imm=0, fmt=0, out_tag=0, SKID contents=0. Asserting rst_n mid-transfer drops all entries immediately, asynchronously.
- Unused upper bits: when XLEN=64, U-type is sign-extended from bit 31.

Test Plan:
- Reset, then issue addi 0xFFF00093 with tag 0x100 and out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, out_tag=0x100.
- Back-to-back stream with out_ready=1:
  - sw 0xFE112E23 -> imm=0xFFFFFFFC, fmt=2.
  - beq 0xFE000CE3 -> imm=0xFFFFFFF8, fmt=3.
  - lui 0x123452B7 -> imm=0x12345000, fmt=4.
  - jal 0xFFDFF06F -> imm=0xFFFFFFFC, fmt=5.
  - srai 0x4030D093 -> imm=0x3, fmt=6.
  - add 0x002081B3 -> imm=0, fmt=0.
  - Required: one result per cycle, in order.
- Backpressure: out_ready=0, push 2 instructions -> in_ready=0 after the second; a third in_valid is ignored. Raise out_ready -> both results delivered in order, in_ready returns to 1 one cycle after the first pop.
- flush in state TWO with simultaneous in_valid -> next cycle out_valid=0, in_ready=1; no entry appears afterwards.
- XLEN=64 build: lui 0x800002B7 -> imm=0xFFFFFFFF80000000; slli 0x03F09093 -> imm=0x3F, fmt=6.
- rst_n pulsed low while in TWO -> out_valid drops immediately; after release, state EMPTY with all outputs zero.
